// File: rtl/cnn_link_pkg.sv
// Shared definitions for cnn_layer_link: bank lifecycle states and the
// helper that sizes word addresses from a bank depth.
package cnn_link_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/link_bank_ram.sv
// One ping-pong bank: simple dual-port RAM, one write and one registered read
// port. The read register only updates on an enabled read, so it holds its
// value otherwise; contents are never cleared by reset.
module link_bank_ram
  import cnn_link_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2562,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_d;
  logic [W-1:0] rdata_q;

  // Write port into the storage array.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Next read data: new word on an enabled read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Registered read output, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cnn_layer_link.sv
// Ping-pong activation buffer between two CNN layers. The producer fills one
// bank while the consumer reads the other; words are requantised on read by a
// left shift. Optional macro LINK_EARLY_START_EN lets a filling bank become
// readable once START_THRESH words are in it.
module cnn_layer_link
  import cnn_link_pkg::*;
#(
  parameter int unsigned CH           = 4,
  parameter int unsigned DW           = 8,
  parameter int unsigned OW           = 17,
  parameter int unsigned SHIFT        = 9,
  parameter int unsigned DEPTH        = 2562,
  parameter int unsigned START_THRESH = 2500
) (
  input  logic                         clk,
  input  logic                         global_rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [CH*DW-1:0]             wr_data,
  input  logic                         rd_en,
  input  logic [addr_width(DEPTH)-1:0] rd_addr,
  output logic [CH*OW-1:0]             rd_data,
  output logic                         rd_valid,
  input  logic                         rd_release,
  output logic                         layer_start,
  output logic                         bank_sel
);

  localparam int unsigned AW = addr_width(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] THRESH    = AW'(START_THRESH);
  localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);

`ifdef LINK_EARLY_START_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  bank_state_e     st_q [2];
  bank_state_e     st_d [2];
  logic [1:0]      filled_q, filled_d;   // bank has received all DEPTH words
  logic            pend_q, pend_d;       // release seen before read bank filled
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic            wbank_q, wbank_d;
  logic            sel_q, sel_d;
  logic            ls_q, ls_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_bank_q, rd_bank_d;

  logic            wr_fire, rd_fire;
  logic [1:0]      ram_we, ram_re;
  logic [CH*DW-1:0] ram_rdata [2];
  logic [CH*DW-1:0] word_sel;

  // Write acceptance: an early-started bank keeps taking words until filled.
  always_comb begin
    wr_ready = 1'b0;
    case (st_q[wbank_q])
      BANK_EMPTY, BANK_FILLING: wr_ready = 1'b1;
      BANK_READING:             wr_ready = EARLY && !filled_q[wbank_q];
      default:                  wr_ready = 1'b0;
    endcase
  end

  // Read qualification; words not yet written to a filling bank are invalid.
  always_comb begin
    wr_fire = wr_valid && wr_ready;
    rd_fire = rd_en && (st_q[sel_q] == BANK_READING)
              && ({1'b0, rd_addr} < DEPTH_X)
              && (filled_q[sel_q] || (rd_addr < wcnt_q));
    ram_we  = {wr_fire && wbank_q, wr_fire && !wbank_q};
    ram_re  = {rd_fire && sel_q, rd_fire && !sel_q};
  end

  // Bank lifecycle: write side advances the write bank, read side promotes
  // and releases the read bank. The two never act on the same bank state in
  // one cycle except early promotion, which deliberately overrides FULL.
  always_comb begin
    st_d       = st_q;
    filled_d   = filled_q;
    pend_d     = pend_q;
    wcnt_d     = wcnt_q;
    wbank_d    = wbank_q;
    sel_d      = sel_q;
    ls_d       = 1'b0;
    rd_valid_d = rd_fire;
    rd_bank_d  = rd_fire ? sel_q : rd_bank_q;

    if (wr_fire) begin
      if (st_q[wbank_q] == BANK_EMPTY) st_d[wbank_q] = BANK_FILLING;
      if (wcnt_q == LAST_ADDR) begin
        if (st_q[wbank_q] != BANK_READING) st_d[wbank_q] = BANK_FULL;
        filled_d[wbank_q] = 1'b1;
        wcnt_d            = '0;
        wbank_d           = ~wbank_q;
      end else begin
        wcnt_d = wcnt_q + AW'(1);
      end
    end

    if ((st_q[sel_q] == BANK_FULL) ||
        (EARLY && (st_q[sel_q] == BANK_FILLING) && (wbank_q == sel_q) && (wcnt_q >= THRESH))) begin
      st_d[sel_q] = BANK_READING;
      ls_d        = 1'b1;
    end

    if ((st_q[sel_q] == BANK_READING) && (rd_release || pend_q)) begin
      if (filled_q[sel_q]) begin
        st_d[sel_q]     = BANK_EMPTY;
        filled_d[sel_q] = 1'b0;
        pend_d          = 1'b0;
        sel_d           = ~sel_q;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (global_rst) begin
      st_q       <= '{default: BANK_EMPTY};
      filled_q   <= '0;
      pend_q     <= 1'b0;
      wcnt_q     <= '0;
      wbank_q    <= 1'b0;
      sel_q      <= 1'b0;
      ls_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      filled_q   <= filled_d;
      pend_q     <= pend_d;
      wcnt_q     <= wcnt_d;
      wbank_q    <= wbank_d;
      sel_q      <= sel_d;
      ls_q       <= ls_d;
      rd_valid_q <= rd_valid_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    link_bank_ram #(
      .W    (CH * DW),
      .DEPTH(DEPTH),
      .AW   (AW)
    ) u_ram (
      .clk  (clk),
      .rst  (global_rst),
      .we   (ram_we[b]),
      .waddr(wcnt_q),
      .wdata(wr_data),
      .re   (ram_re[b]),
      .raddr(rd_addr),
      .rdata(ram_rdata[b])
    );
  end

  // Requantise the last-read word: zero-extend each channel and shift left.
  always_comb begin
    word_sel = ram_rdata[rd_bank_q];
    rd_data  = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      rd_data[c*OW +: OW] = OW'(word_sel[c*DW +: DW]) << SHIFT;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign layer_start = ls_q;
  assign bank_sel    = sel_q;

endmodule

// File: tb/tb_cnn_layer_link.sv
// Bench for cnn_layer_link: directed vectors and corner-case sequences plus
// randomized traffic, all checked every cycle against a bank-queue model.
// Define LINK_EARLY_START_EN to exercise the early-start variant.
`timescale 1ns/1ps
module tb_cnn_layer_link;

  localparam int unsigned CH     = 4;
  localparam int unsigned DW     = 8;
  localparam int unsigned OW     = 17;
  localparam int unsigned SHIFT  = 9;
  localparam int unsigned DEPTH  = 2562;
  localparam int unsigned THRESH = 2500;
  localparam int unsigned AW     = 12;
  localparam int unsigned WW     = CH * DW;
  localparam int unsigned RW     = CH * OW;

`ifdef LINK_EARLY_START_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          global_rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [WW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_release;
  logic          layer_start;
  logic          bank_sel;

  always #5 clk = ~clk;

  cnn_layer_link #(
    .CH(CH), .DW(DW), .OW(OW), .SHIFT(SHIFT), .DEPTH(DEPTH), .START_THRESH(THRESH)
  ) dut (
    .clk(clk), .global_rst(global_rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_release(rd_release), .layer_start(layer_start),
    .bank_sel(bank_sel)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned ls_count = 0;
  bit          ls_bank = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model: each bank is a list of words ----------
  logic [WW-1:0] m_mem [2][DEPTH];
  int unsigned   m_size [2];
  bit            m_pub [2];       // layer_start issued for this bank
  bit            m_pend, m_wb, m_sel, m_ls, m_rv;
  logic [RW-1:0] m_rd;

  function automatic logic [RW-1:0] requant(input logic [WW-1:0] w);
    logic [RW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      longint v;
      v = longint'(w[c*DW +: DW]) * (longint'(1) << SHIFT);
      r[c*OW +: OW] = OW'(v % (longint'(1) << OW));
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] ramp(input int unsigned i);
    logic [WW-1:0] w;
    for (int k = 0; k < CH; k++) w[k*DW +: DW] = DW'((i + k) % 256);
    return w;
  endfunction

  task automatic model_reset();
    m_size[0] = 0; m_size[1] = 0; m_pub[0] = 0; m_pub[1] = 0;
    m_pend = 0; m_wb = 0; m_sel = 0; m_ls = 0; m_rv = 0; m_rd = '0;
  endtask

  task automatic model_step();
    bit acc, rd_ok, promote, do_rel;
    int unsigned ra;
    if (global_rst) begin
      model_reset();
      return;
    end
    ra      = rd_addr;
    acc     = wr_valid && (m_size[m_wb] < DEPTH);
    rd_ok   = rd_en && m_pub[m_sel] && (ra < m_size[m_sel]);
    promote = !m_pub[m_sel] && ((m_size[m_sel] == DEPTH) ||
              (EARLY && (m_wb == m_sel) && (m_size[m_sel] >= THRESH)));
    do_rel  = 0;
    if (m_pub[m_sel] && (rd_release || m_pend)) begin
      if (m_size[m_sel] == DEPTH) do_rel = 1;
      else m_pend = 1;
    end
    m_rv = rd_ok;
    if (rd_ok) m_rd = requant(m_mem[m_sel][ra]);
    if (acc) begin
      m_mem[m_wb][m_size[m_wb]] = wr_data;
      m_size[m_wb]++;
      if (m_size[m_wb] == DEPTH) m_wb = !m_wb;
    end
    m_ls = promote;
    if (promote) m_pub[m_sel] = 1;
    if (do_rel) begin
      m_size[m_sel] = 0; m_pub[m_sel] = 0; m_pend = 0; m_sel = !m_sel;
    end
  endtask

  // ---------------- stimulus helpers ---------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("cycle", {wr_ready, layer_start, bank_sel, rd_valid, rd_data},
                   {(m_size[m_wb] < DEPTH), m_ls, m_sel, m_rv, m_rd});
    if (layer_start) begin
      ls_count++;
      ls_bank = bank_sel;
    end
  endtask

  task automatic push(input logic [WW-1:0] d, output int unsigned waited);
    waited   = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!wr_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!wr_ready) check("push_ready", wr_ready, 1);
    tick();
  endtask

  task automatic fill(input int unsigned first, input int unsigned n, input int unsigned ofs);
    int unsigned w;
    for (int unsigned i = first; i < first + n; i++) push(ramp(i + ofs), w);
  endtask

  task automatic rd(input int unsigned a);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic do_reset();
    global_rst = 1'b1;
    tick();
    global_rst = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          vld;
    int unsigned   ch0;
    int unsigned   ch3;
  } rd_vec_t;

  rd_vec_t vecs [6];

  initial begin
    int unsigned waited;
    int unsigned lim;

    vecs[0] = '{addr: 12'd2562, vld: 1'b0, ch0: 2560,   ch3: 4096};
    vecs[1] = '{addr: 12'd255,  vld: 1'b1, ch0: 130560, ch3: 1024};
    vecs[2] = '{addr: 12'd4095, vld: 1'b0, ch0: 130560, ch3: 1024};
    vecs[3] = '{addr: 12'd2561, vld: 1'b1, ch0: 512,    ch3: 2048};
    vecs[4] = '{addr: 12'd0,    vld: 1'b1, ch0: 0,      ch3: 1536};
    vecs[5] = '{addr: 12'd128,  vld: 1'b1, ch0: 65536,  ch3: 67072};

    global_rst = 1'b1; wr_valid = 1'b0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_layer_start", layer_start, 0);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_rd_data", rd_data, 0);
    global_rst = 1'b0;

    // Fill bank 0 with ramp data.
    ls_count = 0;
    fill(0, DEPTH, 0);
    wr_valid = 1'b0;
    repeat (3) tick();
    check("fill_ls_count", ls_count, 1);
    check("fill_ls_bank", ls_bank, 0);

    // One-cycle read latency.
    rd_en = 1'b1; rd_addr = 12'd5;
    check("lat_before", rd_valid, 0);
    tick();
    rd_en = 1'b0;
    check("lat_valid", rd_valid, 1);
    check("lat_ch0", rd_data[OW-1:0], 5 * 512);
    tick();
    check("lat_drop", rd_valid, 0);

    // Read vector table (invalid reads must hold the previous data).
    for (int v = 0; v < 6; v++) begin
      rd(vecs[v].addr);
      check($sformatf("vec%0d_valid", v), rd_valid, vecs[v].vld);
      check($sformatf("vec%0d_ch0", v), rd_data[0 +: OW], vecs[v].ch0);
      check($sformatf("vec%0d_ch3", v), rd_data[3*OW +: OW], vecs[v].ch3);
    end

    // Fill bank 1 with no release: the next word must stall.
    fill(DEPTH, DEPTH, 0);
    wr_data = ramp(2 * DEPTH);
    for (int k = 0; k < 3; k++) begin
      check("stall_ready", wr_ready, 0);
      tick();
    end
    check("stall_no_start", ls_count, 1);
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    check("rel_ready", wr_ready, 1);
    check("rel_sel", bank_sel, 1);
    push(ramp(2 * DEPTH), waited);
    check("rel_no_wait", waited, 0);
    wr_valid = 1'b0;
    repeat (3) tick();
    check("b1_ls_count", ls_count, 2);
    check("b1_ls_bank", ls_bank, 1);
    rd(0);
    check("b1_first_valid", rd_valid, 1);
    check("b1_first_ch0", rd_data[OW-1:0], 2 * 512);
    rd(DEPTH - 1);
    check("b1_last_ch0", rd_data[OW-1:0], 3 * 512);

    // Release bank 0 on the cycle bank 1 becomes full.
    do_reset();
    fill(0, DEPTH, 0);
    fill(DEPTH, DEPTH - 1, 0);
    wr_valid = 1'b1; wr_data = ramp(2 * DEPTH - 1); rd_release = 1'b1;
    check("same_pre_ready", wr_ready, 1);
    tick();
    rd_release = 1'b0;
    check("same_ready", wr_ready, 1);
    check("same_sel", bank_sel, 1);
    push(ramp(2 * DEPTH), waited);
    check("same_no_gap", waited, 0);
    wr_valid = 1'b0;
    tick();

    // Reset in the middle of a fill.
    do_reset();
    rd(0);
    check("empty_rd_valid", rd_valid, 0);
    fill(0, 1000, 0);
    wr_valid = 1'b0;
    do_reset();
    check("midrst_ready", wr_ready, 1);
    check("midrst_sel", bank_sel, 0);
    ls_count = 0;
    fill(0, DEPTH, 7);
    wr_valid = 1'b0;
    repeat (3) tick();
    check("midrst_ls_count", ls_count, 1);
    check("midrst_ls_bank", ls_bank, 0);
    rd(0);
    check("midrst_ch0", rd_data[OW-1:0], 7 * 512);

`ifdef LINK_EARLY_START_EN
    // Early start on a partially filled bank.
    do_reset();
    ls_count = 0;
    fill(0, THRESH - 1, 0);
    wr_valid = 1'b0;
    repeat (3) tick();
    check("early_none", ls_count, 0);
    fill(THRESH - 1, 1, 0);
    wr_valid = 1'b0;
    repeat (2) tick();
    check("early_ls", ls_count, 1);
    rd(THRESH - 1);
    check("early_rd_valid", rd_valid, 1);
    check("early_rd_ch0", rd_data[OW-1:0], 195 * 512);
    fill(THRESH, 5, 0);
    wr_valid = 1'b0;
    rd(2510);
    check("early_ahead_invalid", rd_valid, 0);
    rd(2504);
    check("early_behind_valid", rd_valid, 1);
    check("early_behind_ch0", rd_data[OW-1:0], 200 * 512);
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    check("early_rel_deferred", bank_sel, 0);
    fill(THRESH + 5, DEPTH - THRESH - 5, 0);
    wr_valid = 1'b0;
    lim = 0;
    while (bank_sel != 1'b1 && lim < 5) begin
      tick();
      lim++;
    end
    check("early_rel_done", bank_sel, 1);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 12000; n++) begin
      wr_valid   = ($urandom_range(0, 9) < 7);
      wr_data    = $urandom();
      rd_en      = $urandom_range(0, 1) == 1;
      rd_addr    = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(DEPTH, 4095))
                                                : AW'($urandom_range(0, DEPTH - 1));
      rd_release = ($urandom_range(0, 299) == 0);
      global_rst = ($urandom_range(0, 5999) == 0);
      tick();
    end
    global_rst = 1'b0; wr_valid = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, limit 5ms", $time);
    $fatal(1);
  end

endmodule

// File: doc/cnn_layer_link.md
CNN_LAYER_LINK -- requirements
Module: cnn_layer_link

Interface
REQ-001 SHALL have parameter CH, default 4: channels carried per word.
REQ-002 SHALL have parameter DW, default 8: input activation width per channel, unsigned.
REQ-003 SHALL have parameter OW, default 17: output activation width per channel.
REQ-004 SHALL have parameter SHIFT, default 9: left shift applied on read; OW >= DW+SHIFT.
REQ-005 SHALL have parameter DEPTH, default 2562: words per bank.
REQ-006 SHALL have parameter START_THRESH, default 2500: early-start write count; START_THRESH < DEPTH.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-008 SHALL have port global_rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port wr_valid, input, 1: producer word valid.
REQ-010 SHALL have port wr_ready, output, 1: buffer accepts the word this cycle.
REQ-011 SHALL have port wr_data, input, CH*DW: channel 0 in the LSBs.
REQ-012 SHALL have port rd_en, input, 1: consumer read request.
REQ-013 SHALL have port rd_addr, input, $clog2(DEPTH): word address in the current read bank.
REQ-014 SHALL have port rd_data, output, CH*OW: requantised word.
REQ-015 SHALL have port rd_valid, output, 1: rd_data valid.
REQ-016 SHALL have port rd_release, input, 1: consumer finished the current read bank.
REQ-017 SHALL have port layer_start, output, 1: one-cycle pulse when a bank becomes readable.
REQ-018 SHALL have port bank_sel, output, 1: index of the current read bank.

Function
REQ-019 SHALL hold two banks (ping-pong); each bank's state is one of EMPTY, FILLING, FULL, READING.
REQ-020 Write handshake SHALL be wr_valid&&wr_ready; each accepted word goes to address wcnt of the write bank, and wcnt increments.
REQ-021 wr_ready SHALL be 1 only when the write bank is EMPTY or FILLING.
REQ-022 The first accepted word SHALL move the write bank EMPTY->FILLING; the word making wcnt==DEPTH SHALL move it to FULL, reset wcnt to 0 and toggle the write bank.
REQ-023 If the new write bank is not EMPTY, wr_ready SHALL be 0 (stall) until it is released; no word is dropped or overwritten.
REQ-024 Read bank SHALL become readable when FULL (or per REQ-035); layer_start SHALL pulse the cycle after, and that bank SHALL enter READING.
REQ-025 Read latency SHALL be 1 cycle: rd_valid and rd_data SHALL be registered from the rd_en/rd_addr of the previous cycle.
REQ-026 rd_en outside READING, or with rd_addr >= DEPTH, SHALL give rd_valid=0 and leave rd_data unchanged.
REQ-027 Per channel, rd_data SHALL equal zero-extended word << SHIFT, truncated to OW.
REQ-028 rd_release in READING SHALL set the bank to EMPTY and toggle bank_sel on the next edge; rd_release in any other state SHALL be ignored.
REQ-029 On the same cycle, a release of bank B and a write-bank switch to bank B SHALL succeed: wr_ready=1 the next cycle.
REQ-030 Simultaneous write and read SHALL proceed on different banks, except for early start (REQ-035).

Reset
REQ-031 On global_rst: both banks EMPTY, wcnt=0, write bank=0, bank_sel=0, wr_ready=1, rd_valid=0, rd_data=0, layer_start=0.
REQ-032 Reset mid-operation SHALL abandon all contents within one cycle; RAM contents need not be cleared.

Configuration
REQ-033 Feature SHALL be gated by macro LINK_EARLY_START_EN.
REQ-034 Without the macro, a bank SHALL become readable only on FULL.
REQ-035 With the macro: a FILLING bank with wcnt >= START_THRESH that is next to read SHALL become READING (layer_start pulses); writes continue; reads with rd_addr >= wcnt SHALL return rd_valid=0; a release before the bank is full SHALL be deferred until the bank is FULL.

Structure
REQ-036 A package cnn_link_pkg SHALL hold the bank-state enum and the address-width helper.
REQ-037 One sub-module, link_bank_ram (1W1R, registered read, CH*DW wide, DEPTH deep), SHALL be instantiated twice.

Verification
REQ-038 Reset: after global_rst, wr_ready=1, rd_valid=0, layer_start=0, bank_sel=0.
REQ-039 Fill: 2562 words of ramp data (ch k = (i+k)%256) -> layer_start pulses once; reading addr 5 gives ch0 = 5*512 and rd_valid 1 cycle later.
REQ-040 Stall: fill both banks with no release -> wr_ready=0 on word 5125; after rd_release, wr_ready=1 next cycle; no data lost.
REQ-041 Same-cycle case: release bank 0 on the same cycle that bank 1 becomes FULL -> writes continue into bank 0 without a gap cycle.
REQ-042 Early start (macro on): layer_start fires after word 2500; read of addr 2499 is valid; read of addr 2510 while wcnt=2505 gives rd_valid=0.
REQ-043 Reset mid-fill at word 1000 -> the next 2562 words produce exactly one layer_start, in bank 0.
